// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   loader_state_type : top-level load sequencing (header, data, run)
//   rx_state_type     : UART byte receiver states
//   UART_DATA_BITS    : data bits per UART frame
//   word_byte_addr    : byte address of a program word
package uart_program_loader_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    L_HEADER,
    L_DATA,
    L_RUN
  } loader_state_type;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_type;

  // Word-granular index to byte address; wraps modulo 2^32.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx_byte.sv
// UART 8N1 byte receiver, LSB first.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   rx         in   raw UART line (asynchronous, idles high)
//   byte_data  out  last received byte (valid while byte_valid is high)
//   byte_valid out  1-cycle pulse: byte received with a good stop bit
//   frame_err  out  1-cycle pulse: stop bit sampled low, byte dropped
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  // Synchroniser plus one history stage for falling-edge detection. All reset
  // to 1 so a line held low through reset is not mistaken for a start bit.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  rx_state_type      state_reg, state_next;
  logic [CNT_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [BIT_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              byte_valid_reg, byte_valid_next;
  logic              frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      state_reg      <= RX_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_sync_reg    <= rx_meta_reg;
      rx_prev_reg    <= rx_sync_reg;
      state_reg      <= state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clk_cnt_next    = clk_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        // Edge-triggered: after a low stop bit the line must return high
        // before another start bit can be recognised.
        if (rx_prev_reg && !rx_sync_reg) begin
          state_next   = RX_START;
          clk_cnt_next = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          // Still low at mid start bit: genuine frame; otherwise a glitch.
          state_next   = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_reg == FULL_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync_reg, shift_reg[7:1]};
          if (bit_idx_reg == LAST_BIT) begin
            state_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_reg == FULL_LAST) begin
          clk_cnt_next = '0;
          state_next   = RX_IDLE;
          if (rx_sync_reg) begin
            byte_valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed program image (32-bit LE
// word count, then count*4 bytes), writes it word by word into program
// memory, then releases the core until it reports completion.
// Ports:
//   clk                      in   system clock, rising edge
//   reset_n                  in   asynchronous active-low reset
//   io_rx                    in   UART receive line (8N1, idles high)
//   run_finished             in   1-cycle pulse from core: program ended
//   program_mem_write_enable out  1-cycle write strobe
//   program_mem_write_data   out  packed word, byte0 in [7:0]
//   uart_write_address       out  byte address BASE_ADDR + 4*word_idx
//   run_flag                 out  level: core may execute
//   indication               out  level: load in progress
//   load_error               out  1-cycle pulse: load aborted
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MEM_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  input  logic        run_finished,
  output logic        program_mem_write_enable,
  output logic [31:0] program_mem_write_data,
  output logic [31:0] uart_write_address,
  output logic        run_flag,
  output logic        indication,
  output logic        load_error
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (io_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  loader_state_type state_reg, state_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [31:0] pack_reg, pack_next;
  logic [31:0] word_count_reg, word_count_next;
  logic [31:0] word_idx_reg, word_idx_next;
  logic        we_reg, we_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] waddr_reg, waddr_next;
  logic        load_error_reg, load_error_next;

  // Little-endian packing: each new byte enters at the top and slides down,
  // so after four bytes the first one received sits in [7:0].
  logic [31:0] assembled;
  logic        last_byte;
  assign assembled = {byte_data, pack_reg[31:8]};
  assign last_byte = (byte_cnt_reg == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= L_HEADER;
      byte_cnt_reg   <= '0;
      pack_reg       <= '0;
      word_count_reg <= '0;
      word_idx_reg   <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      waddr_reg      <= '0;
      load_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      pack_reg       <= pack_next;
      word_count_reg <= word_count_next;
      word_idx_reg   <= word_idx_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      waddr_reg      <= waddr_next;
      load_error_reg <= load_error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    pack_next       = pack_reg;
    word_count_next = word_count_reg;
    word_idx_next   = word_idx_reg;
    we_next         = 1'b0;
    wdata_next      = wdata_reg;
    waddr_next      = waddr_reg;
    load_error_next = 1'b0;
    case (state_reg)
      L_HEADER: begin
        if (frame_err) begin
          load_error_next = 1'b1;
          byte_cnt_next   = '0;
        end else if (byte_valid) begin
          pack_next     = assembled;
          byte_cnt_next = byte_cnt_reg + 1'b1;
          if (last_byte) begin
            word_count_next = assembled;
            if (assembled == 32'd0) begin
              state_next = L_RUN;
            end else if (assembled > 32'(MEM_WORDS)) begin
              load_error_next = 1'b1;
            end else begin
              word_idx_next = '0;
              state_next    = L_DATA;
            end
          end
        end
      end
      L_DATA: begin
        if (frame_err) begin
          // Partial word dropped; words already written stay in memory.
          load_error_next = 1'b1;
          byte_cnt_next   = '0;
          state_next      = L_HEADER;
        end else if (byte_valid) begin
          pack_next     = assembled;
          byte_cnt_next = byte_cnt_reg + 1'b1;
          if (last_byte) begin
            we_next       = 1'b1;
            wdata_next    = assembled;
            waddr_next    = word_byte_addr(BASE_ADDR, word_idx_reg);
            word_idx_next = word_idx_reg + 32'd1;
          end
        end else if (we_reg && (word_idx_reg == word_count_reg)) begin
          // Leave only after the final strobe, so run_flag rises the cycle
          // after the last write rather than alongside it.
          state_next = L_RUN;
        end
      end
      L_RUN: begin
        if (run_finished) begin
          state_next = L_HEADER;
        end
      end
      default: state_next = L_HEADER;
    endcase
  end

  assign program_mem_write_enable = we_reg;
  assign program_mem_write_data   = wdata_reg;
  assign uart_write_address       = waddr_reg;
  assign load_error               = load_error_reg;
  assign run_flag                 = (state_reg == L_RUN);
  assign indication               = (state_reg == L_DATA) ||
                                    ((state_reg == L_HEADER) && (byte_cnt_reg != 2'd0));

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MEMW = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_rx = 1'b1;
  logic        run_finished = 1'b0;
  logic        program_mem_write_enable;
  logic [31:0] program_mem_write_data;
  logic [31:0] uart_write_address;
  logic        run_flag;
  logic        indication;
  logic        load_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE),
    .MEM_WORDS   (MEMW)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .io_rx                   (io_rx),
    .run_finished            (run_finished),
    .program_mem_write_enable(program_mem_write_enable),
    .program_mem_write_data  (program_mem_write_data),
    .uart_write_address      (uart_write_address),
    .run_flag                (run_flag),
    .indication              (indication),
    .load_error              (load_error)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_ev;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_we_cyc = -100;
  int          run_rise_cyc = -100;
  logic        prev_run = 1'b0;
  logic [31:0] words[16];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endfunction

  // Reference model: what the memory side should see for a load.
  function automatic void push_write(input int k);
    ev_t e;
    e.is_err = 1'b0;
    e.addr   = BASE + 32'(4 * k);
    e.data   = words[k];
    exp_q.push_back(e);
  endfunction

  function automatic void push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.addr   = '0;
    e.data   = '0;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expected event per write strobe or load_error pulse.
  always @(negedge clk) begin
    if (program_mem_write_enable || load_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {30'd0, program_mem_write_enable, load_error}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_kind", {31'd0, load_error}, {31'd0, mon_ev.is_err});
        if (!mon_ev.is_err) begin
          check("write_addr", uart_write_address, mon_ev.addr);
          check("write_data", program_mem_write_data, mon_ev.data);
        end
        $display("event: we=%0b err=%0b addr=0x%08h data=0x%08h",
                 program_mem_write_enable, load_error, uart_write_address,
                 program_mem_write_data);
      end
    end
    if (program_mem_write_enable) last_we_cyc = cyc;
    if (run_flag && !prev_run) run_rise_cyc = cyc;
    prev_run = run_flag;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    io_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_finish();
    run_finished = 1'b1;
    @(negedge clk);
    run_finished = 1'b0;
  endtask

  // Sends header + data; err_idx >= 0 forces a low stop bit on that data byte.
  task automatic send_load(input logic [31:0] count, input int nw, input int err_idx,
                           input bit noise);
    bit ok;
    if (count == 32'd0) begin
    end else if (count > 32'(MEMW)) begin
      push_err();
    end else begin
      for (int k = 0; k < nw; k++)
        if (err_idx < 0 || 4 * k + 3 < err_idx) push_write(k);
      if (err_idx >= 0) push_err();
    end
    for (int i = 0; i < 4; i++) send_byte(count[8*i +: 8], 1'b1);
    for (int b = 0; b < 4 * nw; b++) begin
      ok = (b != err_idx);
      send_byte(words[b/4][8*(b%4) +: 8], ok);
      if (!ok) break;
      // run_finished outside L_RUN must not disturb the load.
      if (noise && b < 4 * nw - 1 && $urandom_range(0, 3) == 0) pulse_finish();
    end
    $display("load: count=%0d words_sent=%0d err_idx=%0d", count, nw, err_idx);
  endtask

  task automatic check_run_after_write();
    check("run_flag_after_load", {31'd0, run_flag}, 32'd1);
    check("run_rise_cycle", 32'(run_rise_cyc), 32'(last_we_cyc + 1));
  endtask

  task automatic finish_run();
    check("run_flag_before_finish", {31'd0, run_flag}, 32'd1);
    pulse_finish();
    check("run_flag_after_finish", {31'd0, run_flag}, 32'd0);
    check("indication_after_finish", {31'd0, indication}, 32'd0);
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero();
    check("rst_we", {31'd0, program_mem_write_enable}, 32'd0);
    check("rst_data", program_mem_write_data, 32'd0);
    check("rst_addr", uart_write_address, 32'd0);
    check("rst_run_flag", {31'd0, run_flag}, 32'd0);
    check("rst_indication", {31'd0, indication}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    repeat (20000) @(posedge clk);
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, err;
    repeat (4) @(negedge clk);
    check_all_zero();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: two-word load
    words[0] = 32'h0000_0013;
    words[1] = 32'hDEAD_BEEF;
    send_load(32'd2, 2, -1, 1'b0);
    check_drained("t1_drained");
    check_run_after_write();
    finish_run();

    // 2: empty program runs immediately
    send_load(32'd0, 0, -1, 1'b0);
    check("t2_run_flag", {31'd0, run_flag}, 32'd1);
    send_byte(8'hA5, 1'b1);  // ignored while running
    check_drained("t2_drained");
    finish_run();

    // 4: short low glitch is not a start bit
    io_rx = 1'b0;
    repeat (5) @(negedge clk);
    io_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_indication", {31'd0, indication}, 32'd0);
    check_drained("t4_drained");

    // 3: frame error on 6th data byte, then clean single-word load
    words[0] = $urandom;
    words[1] = $urandom;
    send_load(32'd2, 2, 5, 1'b0);
    check_drained("t3_err_drained");
    check("t3_run_flag", {31'd0, run_flag}, 32'd0);
    words[0] = 32'h0010_0073;
    send_load(32'd1, 1, -1, 1'b0);
    check_drained("t3_drained");
    check_run_after_write();
    finish_run();

    // 5: oversize header
    send_load(32'(MEMW + 1), 0, -1, 1'b0);
    check_drained("t5_drained");
    check("t5_indication", {31'd0, indication}, 32'd0);
    check("t5_run_flag", {31'd0, run_flag}, 32'd0);

    // 6: reset in the middle of the 2nd data word
    words[0] = $urandom | 32'h1;
    words[1] = $urandom;
    push_write(0);
    for (int i = 0; i < 4; i++) send_byte(8'((i == 0) ? 3 : 0), 1'b1);
    for (int b = 0; b < 6; b++) send_byte(words[b/4][8*(b%4) +: 8], 1'b1);
    io_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_indication_before", {31'd0, indication}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero();
    io_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_drained("t6_reset_drained");
    words[0] = $urandom;
    send_load(32'd1, 1, -1, 1'b0);
    check_drained("t6_drained");
    check_run_after_write();
    finish_run();

    // Randomised loads, some with a corrupted stop bit
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) words[k] = $urandom;
      err = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * n - 1)) : -1;
      send_load(32'(n), n, err, 1'b1);
      check_drained("rand_drained");
      if (err < 0) begin
        check_run_after_write();
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
        finish_run();
      end else begin
        check("rand_err_run_flag", {31'd0, run_flag}, 32'd0);
        check("rand_err_indication", {31'd0, indication}, 32'd0);
      end
    end

    repeat (20) @(negedge clk);
    check_drained("final_drained");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
